// File: rtl/acc3_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acc3_ctrl_pkg
// Shared definitions for the cascaded-accumulator frame controller:
//   - state_e     : controller state encoding (IDLE / RUN / DONE)
//   - DEF_IN_W    : default sample width
//   - DEF_ACC_W   : default accumulator / result width
//   - DEF_LEN_W   : default frame-length width
// -----------------------------------------------------------------------------
package acc3_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_ACC_W = 8;
    localparam int DEF_LEN_W = 5;

endpackage : acc3_ctrl_pkg

// File: rtl/acc3_chain.sv
// -----------------------------------------------------------------------------
// acc3_chain
// Three cascaded accumulators that advance together by one step when enabled:
//   a1 <= a1 + in ; a2 <= a2 + a1 ; a3 <= a3 + a1 + a2   (old values, mod 2^ACC_W)
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-high reset, zeroes all stages
//   clr     in   synchronous clear of all stages (wins over en)
//   en      in   advance the chain once this cycle
//   in      in   IN_W-bit unsigned sample
//   a3_nxt  out  stage-3 value that the current advance produces
//   carry   out  per-stage wrap flags of the current advance {s3, s2, s1}
// -----------------------------------------------------------------------------
module acc3_chain
    import acc3_ctrl_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [ACC_W-1:0] a3_nxt,
    output logic [2:0]       carry
);

    logic [ACC_W-1:0] r_a1;
    logic [ACC_W-1:0] r_a2;
    logic [ACC_W-1:0] r_a3;

    // Sums are widened so the true (unwrapped) result is visible for carry
    // detection; stage 3 adds three operands and so needs two extra bits.
    logic [ACC_W:0]   w_sum1;
    logic [ACC_W:0]   w_sum2;
    logic [ACC_W+1:0] w_sum3;

    assign w_sum1 = {1'b0, r_a1} + {{(ACC_W + 1 - IN_W){1'b0}}, in};
    assign w_sum2 = {1'b0, r_a2} + {1'b0, r_a1};
    assign w_sum3 = {2'b00, r_a3} + {2'b00, r_a1} + {2'b00, r_a2};

    assign a3_nxt = w_sum3[ACC_W-1:0];
    assign carry  = {(|w_sum3[ACC_W+1:ACC_W]), w_sum2[ACC_W], w_sum1[ACC_W]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a1 <= '0;
            r_a2 <= '0;
            r_a3 <= '0;
        end else if (clr) begin
            r_a1 <= '0;
            r_a2 <= '0;
            r_a3 <= '0;
        end else if (en) begin
            r_a1 <= w_sum1[ACC_W-1:0];
            r_a2 <= w_sum2[ACC_W-1:0];
            r_a3 <= w_sum3[ACC_W-1:0];
        end
    end

endmodule : acc3_chain

// File: rtl/acc3_frame_ctrl.sv
// -----------------------------------------------------------------------------
// acc3_frame_ctrl
// Frame controller around the three-stage cascaded accumulator. A frame of
// frame_len samples is accepted over a valid/ready handshake, then the final
// stage-3 value is offered over an output valid/ready handshake.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   begin a frame (IDLE only, frame_len must be non-zero)
//   frame_len  in   samples in the frame, latched on an accepted start
//   abort      in   abandon the current frame, back to IDLE without a result
//   in_valid   in   sample present on in_data
//   in_data    in   unsigned sample
//   in_ready   out  controller takes a sample this cycle (high in RUN)
//   out_valid  out  result available (high in DONE)
//   out_ready  in   consumer takes the result
//   result     out  final stage-3 value, held after the frame ends
//   overflow   out  some stage wrapped during the frame
//   busy       out  controller not idle
// -----------------------------------------------------------------------------
module acc3_frame_ctrl
    import acc3_ctrl_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_nxt;

    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_result;
    logic             r_ovf;

    logic             w_start_acc;
    logic             w_accept;
    logic             w_last;
    logic             w_clr;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [ACC_W-1:0] w_a3_nxt;
    logic [2:0]       w_carry;

    // Both qualifiers decode the state register directly rather than the
    // in_ready output, so no combinational path loops through the FSM block.
    assign w_start_acc = (r_state == IDLE) && start && (frame_len != '0);
    // abort outranks a sample arriving in the same cycle.
    assign w_accept    = (r_state == RUN) && in_valid && !abort;
    assign w_cnt_inc   = r_cnt + LEN_W'(1);
    assign w_last      = w_accept && (w_cnt_inc == r_len);
    assign w_clr       = w_start_acc || abort;

    acc3_chain #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_chain (
        .clock  (clock),
        .reset  (reset),
        .clr    (w_clr),
        .en     (w_accept),
        .in     (in_data),
        .a3_nxt (w_a3_nxt),
        .carry  (w_carry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start_acc) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The result is captured from the chain's final advance so it is already
    // correct on the first DONE cycle and survives every later clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_start_acc) begin
            r_len <= frame_len;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | (|w_carry);
            if (w_last) begin
                r_result <= w_a3_nxt;
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_ovf;

endmodule : acc3_frame_ctrl
